// File: rtl/sort_mem_responder_if.sv
// sort_mem_responder_if: read (AR/R) and write (AW/W/B) channels
// between the sort engine (master) and its memory (slave).
interface sort_mem_responder_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
);
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output ar_valid, ar_address, r_ready,
        output aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_address, r_ready,
        input  aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/sort_mem_responder.sv
// sort_mem_responder: array memory behind the sort engine's AR/R + AW/W/B port.
// Optional SORT_MEM_RESP_ERR_EN: out-of-range (>= arr_size) accesses return ERROR.
module sort_mem_responder #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_WDTH-1:0] arr_size,
    sort_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WDTH;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic       {W_IDLE, W_RESP} wr_state_t;

    logic [DATA_WDTH-1:0] mem [DEPTH];

    rd_state_t            rd_state;
    logic [LAT_W-1:0]     lat_cnt;
    logic [ADDR_WDTH-1:0] ar_addr_q;
    logic [ADDR_WDTH-1:0] rd_addr;
    logic                 rd_err;

    wr_state_t            wr_state;
    logic                 aw_got;
    logic                 w_got;
    logic [ADDR_WDTH-1:0] aw_addr_q;
    logic [DATA_WDTH-1:0] w_data_q;
    logic                 aw_hs;
    logic                 w_hs;
    logic [ADDR_WDTH-1:0] wr_addr;
    logic [DATA_WDTH-1:0] wr_data;
    logic                 wr_err;

    // With READ_LAT=1 the sample happens on the AR handshake edge itself.
    assign rd_addr = (rd_state == R_IDLE) ? bus.ar_address : ar_addr_q;

    assign aw_hs   = bus.aw_valid && bus.aw_ready;
    assign w_hs    = bus.w_valid && bus.w_ready;
    assign wr_addr = aw_hs ? bus.aw_address : aw_addr_q;
    assign wr_data = w_hs ? bus.w_data : w_data_q;

`ifdef SORT_MEM_RESP_ERR_EN
    assign rd_err = (rd_addr >= arr_size);
    assign wr_err = (wr_addr >= arr_size);
`else
    logic unused_arr_size;
    assign unused_arr_size = ^arr_size;
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            lat_cnt      <= '0;
            ar_addr_q    <= '0;
            bus.ar_ready <= 1'b0;
            bus.r_valid  <= 1'b0;
            bus.r_data   <= '0;
            bus.r_resp   <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (bus.ar_valid && bus.ar_ready) begin
                        ar_addr_q    <= bus.ar_address;
                        bus.ar_ready <= 1'b0;
                        lat_cnt      <= LAT_W'(READ_LAT - 1);
                        if (READ_LAT == 1) begin
                            bus.r_valid <= 1'b1;
                            bus.r_data  <= rd_err ? '0 : mem[rd_addr];
                            bus.r_resp  <= RESP_WDTH'(rd_err);
                            rd_state    <= R_RESP;
                        end else begin
                            rd_state <= R_WAIT;
                        end
                    end else begin
                        bus.ar_ready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        bus.r_valid <= 1'b1;
                        bus.r_data  <= rd_err ? '0 : mem[rd_addr];
                        bus.r_resp  <= RESP_WDTH'(rd_err);
                        rd_state    <= R_RESP;
                    end
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                R_RESP: begin
                    if (bus.r_ready) begin
                        bus.r_valid  <= 1'b0;
                        bus.ar_ready <= 1'b1;
                        rd_state     <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            bus.aw_ready <= 1'b0;
            bus.w_ready  <= 1'b0;
            bus.b_valid  <= 1'b0;
            bus.b_resp   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (aw_hs) aw_addr_q <= bus.aw_address;
                    if (w_hs)  w_data_q  <= bus.w_data;
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        if (!wr_err) mem[wr_addr] <= wr_data;
                        bus.b_valid  <= 1'b1;
                        bus.b_resp   <= RESP_WDTH'(wr_err);
                        bus.aw_ready <= 1'b0;
                        bus.w_ready  <= 1'b0;
                        aw_got       <= 1'b0;
                        w_got        <= 1'b0;
                        wr_state     <= W_RESP;
                    end else begin
                        aw_got       <= aw_got || aw_hs;
                        w_got        <= w_got || w_hs;
                        bus.aw_ready <= !(aw_got || aw_hs);
                        bus.w_ready  <= !(w_got || w_hs);
                    end
                end
                W_RESP: begin
                    if (bus.b_ready) begin
                        bus.b_valid  <= 1'b0;
                        bus.aw_ready <= 1'b1;
                        bus.w_ready  <= 1'b1;
                        wr_state     <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_mem_responder.sv
// tb_sort_mem_responder: directed checks of reset, reads, writes,
// split write, backpressure, collision, range errors and mid-read reset.
module tb_sort_mem_responder;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int RW  = 1;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] arr_size = 4'd8;

    int total = 0;
    int bad   = 0;

    sort_mem_responder_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();

    sort_mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .READ_LAT(LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arr_size(arr_size),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr,
                           input logic [31:0] exp_data, input logic exp_resp);
        int n;
        bus.ar_valid   = 1'b1;
        bus.ar_address = addr;
        n = 0;
        while (!bus.ar_ready && n < 20) begin step(); n++; end
        check({tag, "_ar_rdy"}, 32'(bus.ar_ready), 32'd1);
        step();
        bus.ar_valid = 1'b0;
        n = 0;
        while (!bus.r_valid && n < 20) begin step(); n++; end
        // r_valid is registered on edge N+LAT-1 after the AR edge N
        check({tag, "_lat"}, 32'(n), 32'(LAT - 1));
        check({tag, "_data"}, bus.r_data, exp_data);
        check({tag, "_resp"}, 32'(bus.r_resp), 32'(exp_resp));
        step();
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] addr,
                            input logic [31:0] data, input logic exp_resp);
        int n;
        bus.aw_valid   = 1'b1;
        bus.aw_address = addr;
        bus.w_valid    = 1'b1;
        bus.w_data     = data;
        n = 0;
        while (!(bus.aw_ready && bus.w_ready) && n < 20) begin step(); n++; end
        step();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        check({tag, "_bvld"}, 32'(bus.b_valid), 32'd1);
        check({tag, "_bresp"}, 32'(bus.b_resp), 32'(exp_resp));
        step();
    endtask

    initial begin
        bus.ar_valid   = 1'b0;
        bus.ar_address = '0;
        bus.r_ready    = 1'b1;
        bus.aw_valid   = 1'b0;
        bus.aw_address = '0;
        bus.w_valid    = 1'b0;
        bus.w_data     = '0;
        bus.b_ready    = 1'b1;

        repeat (3) step();
        check("rst_ar_rdy", 32'(bus.ar_ready), 32'd0);
        check("rst_aw_rdy", 32'(bus.aw_ready), 32'd0);
        check("rst_w_rdy", 32'(bus.w_ready), 32'd0);
        check("rst_r_vld", 32'(bus.r_valid), 32'd0);
        check("rst_b_vld", 32'(bus.b_valid), 32'd0);
        check("rst_r_data", bus.r_data, 32'd0);

        rst = 1'b0;
        step();
        check("idle_ar_rdy", 32'(bus.ar_ready), 32'd1);
        check("idle_aw_rdy", 32'(bus.aw_ready), 32'd1);
        check("idle_w_rdy", 32'(bus.w_ready), 32'd1);
        check("idle_r_vld", 32'(bus.r_valid), 32'd0);
        check("idle_b_vld", 32'(bus.b_valid), 32'd0);

        do_read("rd0", 4'd0, 32'd0, 1'b0);
        do_read("rd15", 4'd15, 32'd0, 1'b0);

        do_write("wr3", 4'd3, 32'hDEADBEEF, 1'b0);
        do_read("rd3", 4'd3, 32'hDEADBEEF, 1'b0);

        // W three cycles ahead of AW
        bus.w_valid = 1'b1;
        bus.w_data  = 32'h11;
        step();
        bus.w_valid = 1'b0;
        check("split_w_rdy", 32'(bus.w_ready), 32'd0);
        check("split_aw_rdy", 32'(bus.aw_ready), 32'd1);
        check("split_b_vld0", 32'(bus.b_valid), 32'd0);
        step();
        step();
        check("split_w_rdy2", 32'(bus.w_ready), 32'd0);
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd5;
        step();
        bus.aw_valid = 1'b0;
        check("split_b_vld", 32'(bus.b_valid), 32'd1);
        check("split_b_resp", 32'(bus.b_resp), 32'd0);
        step();
        do_read("rd5", 4'd5, 32'h11, 1'b0);

        // both responses stalled while read and write run together
        bus.r_ready    = 1'b0;
        bus.b_ready    = 1'b0;
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd3;
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd2;
        bus.w_valid    = 1'b1;
        bus.w_data     = 32'h22;
        step();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("bp_r_vld", 32'(bus.r_valid), 32'd1);
            check("bp_r_data", bus.r_data, 32'hDEADBEEF);
            check("bp_b_vld", 32'(bus.b_valid), 32'd1);
            check("bp_b_resp", 32'(bus.b_resp), 32'd0);
            check("bp_ar_rdy", 32'(bus.ar_ready), 32'd0);
            check("bp_aw_rdy", 32'(bus.aw_ready), 32'd0);
            check("bp_w_rdy", 32'(bus.w_ready), 32'd0);
            step();
        end
        bus.r_ready = 1'b1;
        bus.b_ready = 1'b1;
        step();
        check("bp_r_done", 32'(bus.r_valid), 32'd0);
        check("bp_b_done", 32'(bus.b_valid), 32'd0);
        check("bp_ar_back", 32'(bus.ar_ready), 32'd1);
        check("bp_aw_back", 32'(bus.aw_ready), 32'd1);
        do_read("rd2", 4'd2, 32'h22, 1'b0);

        // write of 0xB commits on the same edge the read samples addr 7
        do_write("wr7a", 4'd7, 32'hA, 1'b0);
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd7;
        step();
        bus.ar_valid   = 1'b0;
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd7;
        bus.w_valid    = 1'b1;
        bus.w_data     = 32'hB;
        step();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        check("col_r_vld", 32'(bus.r_valid), 32'd1);
        check("col_r_old", bus.r_data, 32'hA);
        check("col_b_vld", 32'(bus.b_valid), 32'd1);
        step();
        do_read("rd7b", 4'd7, 32'hB, 1'b0);

`ifdef SORT_MEM_RESP_ERR_EN
        do_write("wr9_err", 4'd9, 32'h99, 1'b1);
        do_read("rd9_err", 4'd9, 32'd0, 1'b1);
        do_read("rd3_keep", 4'd3, 32'hDEADBEEF, 1'b0);
`else
        do_write("wr9", 4'd9, 32'h99, 1'b0);
        do_read("rd9", 4'd9, 32'h99, 1'b0);
`endif

        // reset while the read is waiting on latency
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd3;
        step();
        bus.ar_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mr_r_vld0", 32'(bus.r_valid), 32'd0);
        check("mr_ar_rdy0", 32'(bus.ar_ready), 32'd0);
        rst = 1'b0;
        step();
        check("mr_ar_rdy", 32'(bus.ar_ready), 32'd1);
        check("mr_r_vld1", 32'(bus.r_valid), 32'd0);
        step();
        check("mr_r_vld2", 32'(bus.r_valid), 32'd0);
        do_read("rd3_clr", 4'd3, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sort_mem_responder.md
# sort_mem_responder

Memory responder for the insertion-sort engine: accepts the engine's read (AR/R) and write (AW/W/B) transactions and services them from an internal array of 2^ADDR_WDTH words. It sits on the far side of the sort datapath's memory interface and holds the array being sorted. It also acts as the reference memory model in block and top-level benches. Read and write channels are independent and may be active at the same time.

## Interface
- ADDR_WDTH, 4, address width; array depth = 2^ADDR_WDTH words
- DATA_WDTH, 32, word width
- RESP_WDTH, 1, response width; 0 = OKAY, 1 = ERROR (LSB), upper bits 0
- READ_LAT, 2, cycles from AR handshake to r_valid; legal range 1..15
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- arr_size  input  ADDR_WDTH  number of valid elements; used only by error checking
- ar_valid  input  1  read address valid
- ar_ready  output  1  read address accepted
- ar_address  input  ADDR_WDTH  read word address
- r_valid  output  1  read data valid
- r_ready  input  1  initiator accepts read data
- r_data  output  DATA_WDTH  read data
- r_resp  output  RESP_WDTH  read response
- aw_valid  input  1  write address valid
- aw_ready  output  1  write address accepted
- aw_address  input  ADDR_WDTH  write word address
- w_valid  input  1  write data valid
- w_ready  output  1  write data accepted
- w_data  input  DATA_WDTH  write data
- b_valid  output  1  write response valid
- b_ready  input  1  initiator accepts write response
- b_resp  output  RESP_WDTH  write response

## Operation
- All outputs registered. Handshake on any channel = valid && ready at a rising edge. Valid, once high, holds with stable payload until its handshake.
- Read FSM: R_IDLE (ar_ready=1) -> AR handshake latches ar_address, loads latency counter with READ_LAT-1 -> R_WAIT (ar_ready=0) counts down -> at count 0, memory sampled into r_data, r_valid=1 -> R_RESP until r_ready -> R_IDLE. With READ_LAT=1, R_WAIT lasts zero cycles: r_valid rises the cycle after AR handshake.
- Write FSM: W_IDLE (aw_ready=1, w_ready=1). AW and W may handshake in either order or the same cycle. Each ready drops the cycle after its own handshake (one outstanding write). At the edge where the second of the two handshakes completes, mem[aw_address] <= w_data and b_valid rises -> W_RESP until b_ready -> W_IDLE; both readies high the cycle after b handshake.
- Read/write collision: if a write commits at the same edge as the read sample, r_data returns the old value. A write committed on any earlier edge is visible.
- Memory cleared to 0 on reset.
- Reset mid-operation: both FSMs return to idle; pending read and uncommitted write discarded; no response issued.

## Timing
- Reset values: ar_ready=0, aw_ready=0, w_ready=0, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0. Readies go 1 in the first cycle after rst deasserts.
- Read: AR handshake at edge N -> r_valid high from cycle N+READ_LAT. Minimum back-to-back read spacing: READ_LAT+1 cycles, r_ready held high.
- Write: final AW/W handshake at edge N -> b_valid high from cycle N+1, memory updated at edge N. Minimum write spacing: 2 cycles, b_ready held high.
- Addresses wrap naturally at 2^ADDR_WDTH. No address arithmetic is performed.

## Configuration
- SORT_MEM_RESP_ERR_EN defined: a read with ar_address >= arr_size returns r_data=0 and r_resp=1. A write with aw_address >= arr_size is not committed and returns b_resp=1. Handshake timing is unchanged.
- SORT_MEM_RESP_ERR_EN undefined: r_resp and b_resp are tied 0. arr_size is ignored. All 2^ADDR_WDTH addresses are readable and writable.

## Test plan
- Reset then idle: after rst release, readies = 1 next cycle; all valids 0. A read of any address returns 0.
- Write/read: write 0xDEADBEEF to addr 3 (AW and W same cycle) -> b_valid the next cycle, b_resp=0. A read of addr 3 (READ_LAT=2) -> r_valid 2 cycles after AR, r_data=0xDEADBEEF.
- Split write order: W (0x11) 3 cycles before AW (addr 5) -> w_ready low after the W handshake, commit at the AW handshake. A read of addr 5 returns 0x11.
- Backpressure: hold r_ready=0 and b_ready=0 for 4 cycles -> r_valid, b_valid and their payloads stay stable. No new AR/AW/W accepted until the response handshakes.
- Collision: addr 7 = 0xA, then a write of 0xB to addr 7 committing at the read-sample edge -> r_data=0xA; a following read returns 0xB.
- SORT_MEM_RESP_ERR_EN, arr_size=8: a write to addr 9 -> b_resp=1 and mem unchanged. A read of addr 9 -> r_resp=1, r_data=0. Assert rst during R_WAIT -> no r_valid, ar_ready=1 after release.
